// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding and address helpers for the cache line
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WBACK  = 3'd1,
    ST_REFILL = 3'd2,
    ST_COMMIT = 3'd3,
    ST_SYNC   = 3'd4,
    ST_FLUSH  = 3'd5
  } state_t;

  function automatic int unsigned beats_per_line(input int unsigned beat_wid);
    return 32'd1 << beat_wid;
  endfunction

  // Caller truncates the result to its own address width.
  function automatic logic [63:0] make_bus_addr(input logic [63:0]   tag,
                                                input logic [63:0]   beat,
                                                input int unsigned   tag_lsb,
                                                input int unsigned   byte_off);
    return (tag << tag_lsb) | (beat << byte_off);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_beat_agu.sv
`default_nettype none
// ============================================================================
// Module      : cache_beat_agu
// Description : Line beat counter and bus address generator for one burst.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_beat_agu
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_LSB    = 12,
  parameter int BYTE_OFF   = 2,
  parameter int BEAT_WID   = TAG_LSB - BYTE_OFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        ack,
  input  logic                        tag_sel,
  input  logic [ADDR_WIDTH-TAG_LSB-1:0] victim_tag,
  input  logic [ADDR_WIDTH-TAG_LSB-1:0] miss_tag,
  output logic [BEAT_WID-1:0]         beat,
  output logic                        last,
  output logic [ADDR_WIDTH-1:0]       bus_addr
);

  localparam logic [BEAT_WID-1:0] c_last_beat = BEAT_WID'(beats_per_line(BEAT_WID) - 1);

  logic [BEAT_WID-1:0]           r_beat;
  logic [ADDR_WIDTH-TAG_LSB-1:0] w_tag;

  // The counter wraps naturally after the final beat of a line.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_beat <= '0;
    end else if (ack) begin
      r_beat <= r_beat + 1'b1;
    end
  end

  assign w_tag    = tag_sel ? victim_tag : miss_tag;
  assign beat     = r_beat;
  assign last     = (r_beat == c_last_beat);
  assign bus_addr = ADDR_WIDTH'(make_bus_addr(64'(w_tag), 64'(r_beat), TAG_LSB, BYTE_OFF));

endmodule
`default_nettype wire

// File: rtl/cache_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cache_line_sequencer
// Description : Sequences victim write-back, line refill, sync and flush
//               between the tag manager, data RAM and system bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_line_sequencer
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_LSB      = 12,
  parameter int BYTE_OFF     = 2,
  parameter int BEAT_WID     = TAG_LSB - BYTE_OFF,
  parameter int ENTRYSEL_WID = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_req,
  input  logic [ADDR_WIDTH-1:0]         core_addr,
  output logic                          core_stall,
  input  logic                          line_miss,
  input  logic                          replace_dirty,
  input  logic [ENTRYSEL_WID-1:0]       replace_sel,
  input  logic [ADDR_WIDTH-TAG_LSB-1:0] victim_tag,
  output logic                          line_refill,
  output logic [ADDR_WIDTH-1:0]         refill_pa,
  output logic                          writeback_ok,
  output logic                          force_sync,
  output logic                          valid_clear,
  input  logic                          sync_req,
  output logic                          sync_done,
  input  logic                          flush_req,
  output logic                          bus_req,
  output logic                          bus_we,
  output logic [ADDR_WIDTH-1:0]         bus_addr,
  input  logic                          bus_ack,
  output logic [ENTRYSEL_WID-1:0]       mem_entry,
  output logic [BEAT_WID-1:0]           mem_beat,
  output logic                          mem_we
);

  state_t                        r_state;
  logic [ENTRYSEL_WID-1:0]       r_ent;
  logic [ADDR_WIDTH-TAG_LSB-1:0] r_vtag;
  logic [ADDR_WIDTH-1:0]         r_maddr;
  logic                          r_sync;

  logic w_in_wback;
  logic w_in_refill;
  logic w_ack;
  logic w_last;
  logic w_idle;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_in_wback  = (r_state == ST_WBACK);
  assign w_in_refill = (r_state == ST_REFILL);
  assign w_ack       = bus_ack & (w_in_wback | w_in_refill);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ent   <= '0;
      r_vtag  <= '0;
      r_maddr <= '0;
      r_sync  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_state <= ST_FLUSH;
          end else if (sync_req) begin
            r_state <= ST_SYNC;
            r_sync  <= 1'b1;
          end else if (core_req && line_miss) begin
            r_ent   <= replace_sel;
            r_vtag  <= victim_tag;
            r_maddr <= core_addr;
            r_state <= replace_dirty ? ST_WBACK : ST_REFILL;
          end
        end
        ST_FLUSH:  r_state <= ST_IDLE;
        ST_WBACK: begin
          if (w_ack && w_last) begin
            r_state <= r_sync ? ST_SYNC : ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (w_ack && w_last) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: r_state <= ST_IDLE;
        ST_SYNC: begin
          // Tag manager presents the next dirty line each time we return here.
          if (replace_dirty) begin
            r_ent   <= replace_sel;
            r_vtag  <= victim_tag;
            r_state <= ST_WBACK;
          end else begin
            r_sync  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  cache_beat_agu #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TAG_LSB    (TAG_LSB),
    .BYTE_OFF   (BYTE_OFF),
    .BEAT_WID   (BEAT_WID)
  ) u_agu (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_idle),
    .ack        (w_ack),
    .tag_sel    (w_in_wback),
    .victim_tag (r_vtag),
    .miss_tag   (r_maddr[ADDR_WIDTH-1:TAG_LSB]),
    .beat       (mem_beat),
    .last       (w_last),
    .bus_addr   (bus_addr)
  );

  assign bus_req      = w_in_wback | w_in_refill;
  assign bus_we       = w_in_wback;
  assign mem_we       = w_in_refill & bus_ack;
  assign mem_entry    = r_ent;
  assign writeback_ok = w_in_wback & w_ack & w_last;
  assign line_refill  = (r_state == ST_COMMIT);
  assign refill_pa    = r_maddr;
  assign valid_clear  = (r_state == ST_FLUSH);
  assign force_sync   = (r_state == ST_SYNC) | (w_in_wback & r_sync);
  assign sync_done    = (r_state == ST_SYNC) & ~replace_dirty;
  assign core_stall   = ~w_idle | (core_req & line_miss) | flush_req | sync_req;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_line_sequencer
// Description : Scoreboard bench for cache_line_sequencer (16-beat lines).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_line_sequencer;

  localparam int K_BUS  = 1;
  localparam int K_WBOK = 2;
  localparam int K_LREF = 3;
  localparam int K_VCLR = 4;
  localparam int K_SDON = 5;

  typedef struct packed {
    logic [2:0]  kind;
    logic        we;
    logic        mw;
    logic [31:0] addr;
    logic [2:0]  ent;
    logic [3:0]  beat;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, line_miss, replace_dirty, sync_req, flush_req, bus_ack;
  logic [31:0] core_addr;
  logic [2:0]  replace_sel;
  logic [25:0] victim_tag;
  logic        core_stall, line_refill, writeback_ok, force_sync, valid_clear;
  logic        sync_done, bus_req, bus_we, mem_we;
  logic [31:0] refill_pa, bus_addr;
  logic [2:0]  mem_entry;
  logic [3:0]  mem_beat;

  int  checks   = 0;
  int  failures = 0;
  logic exp_force = 1'b0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  cache_line_sequencer #(
    .ADDR_WIDTH(32), .TAG_LSB(6), .BYTE_OFF(2), .ENTRYSEL_WID(3)
  ) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_addr(core_addr),
    .core_stall(core_stall), .line_miss(line_miss), .replace_dirty(replace_dirty),
    .replace_sel(replace_sel), .victim_tag(victim_tag), .line_refill(line_refill),
    .refill_pa(refill_pa), .writeback_ok(writeback_ok), .force_sync(force_sync),
    .valid_clear(valid_clear), .sync_req(sync_req), .sync_done(sync_done),
    .flush_req(flush_req), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_ack(bus_ack), .mem_entry(mem_entry), .mem_beat(mem_beat), .mem_we(mem_we)
  );

  function automatic ev_t mk(input int kind, input logic we, input logic mw,
                             input logic [31:0] addr, input logic [2:0] ent,
                             input logic [3:0] beat);
    ev_t e;
    e.kind = 3'(kind); e.we = we; e.mw = mw; e.addr = addr; e.ent = ent; e.beat = beat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic observe(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got %0h expected none at %0t", got, $time);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL sb_event: got %0h expected %0h at %0t", got, want, $time);
      end
    end
  endtask

  // Monitor: every observable DUT event is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && bus_ack) observe(mk(K_BUS, bus_we, mem_we, bus_addr, mem_entry, mem_beat));
      if (writeback_ok)       observe(mk(K_WBOK, 1'b0, 1'b0, 32'h0, 3'h0, 4'h0));
      if (line_refill)        observe(mk(K_LREF, 1'b0, 1'b0, refill_pa, 3'h0, 4'h0));
      if (valid_clear)        observe(mk(K_VCLR, 1'b0, 1'b0, 32'h0, 3'h0, 4'h0));
      if (sync_done)          observe(mk(K_SDON, 1'b0, 1'b0, 32'h0, 3'h0, 4'h0));
      if (mem_we && !(bus_req && bus_ack && !bus_we)) begin
        checks++;
        failures++;
        $display("FAIL mem_we_stray: got 1 expected 0 at %0t", $time);
      end
      if (exp_force) chk("force_sync_held", 64'(force_sync), 64'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic we, input logic [31:0] base, input logic [2:0] ent,
                            input int first, input int count);
    for (int b = first; b < first + count; b++)
      exp_q.push_back(mk(K_BUS, we, ~we, base + 32'(4 * b), ent, 4'(b)));
  endtask

  task automatic push_pulse(input int kind, input logic [31:0] addr);
    exp_q.push_back(mk(kind, 1'b0, 1'b0, addr, 3'h0, 4'h0));
  endtask

  task automatic burst(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      if (i != n - 1) repeat (gap) tick();
    end
  endtask

  task automatic start_miss(input logic [31:0] addr, input logic [2:0] sel,
                            input logic [25:0] vtag, input logic dirty);
    core_req = 1'b1; line_miss = 1'b1; core_addr = addr;
    replace_sel = sel; victim_tag = vtag; replace_dirty = dirty;
    #1 chk("stall_on_miss", 64'(core_stall), 64'd1);
    tick();
    chk("bus_req_start", 64'(bus_req), 64'd1);
    // Tag manager outputs wander after the latch; the burst must ignore them.
    replace_sel = ~sel; victim_tag = 26'h155_5555; replace_dirty = 1'b0;
  endtask

  task automatic finish_miss();
    for (int i = 0; i < 8 && !line_refill; i++) tick();
    chk("line_refill_seen", 64'(line_refill), 64'd1);
    core_req = 1'b0; line_miss = 1'b0;
    tick();
    chk("stall_released", 64'(core_stall), 64'd0);
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; line_miss = 1'b0; replace_dirty = 1'b0;
    sync_req = 1'b0; flush_req = 1'b0; bus_ack = 1'b0;
    core_addr = 32'h0; replace_sel = 3'h0; victim_tag = 26'h0;
    repeat (3) tick();
    chk("rst_bus_req",   64'(bus_req),    64'd0);
    chk("rst_stall",     64'(core_stall), 64'd0);
    chk("rst_force",     64'(force_sync), 64'd0);
    chk("rst_mem_entry", 64'(mem_entry),  64'd0);
    chk("rst_mem_beat",  64'(mem_beat),   64'd0);
    chk("rst_refill_pa", 64'(refill_pa),  64'd0);
    chk("rst_bus_addr",  64'(bus_addr),   64'd0);
    rst = 1'b0;
    tick();

    // 1: clean miss, ack every other cycle
    push_burst(1'b0, 32'h1240, 3'd5, 0, 16);
    push_pulse(K_LREF, 32'h1240);
    start_miss(32'h1240, 3'd5, 26'h2AA, 1'b0);
    chk("clean_read", 64'(bus_we), 64'd0);
    burst(16, 1);
    finish_miss();

    // 2: dirty miss, write-back then refill
    push_burst(1'b1, 32'hE80, 3'd3, 0, 16);
    push_pulse(K_WBOK, 32'h0);
    push_burst(1'b0, 32'h80, 3'd3, 0, 16);
    push_pulse(K_LREF, 32'h80);
    start_miss(32'h80, 3'd3, 26'h3A, 1'b1);
    chk("wback_we", 64'(bus_we), 64'd1);
    burst(16, 0);
    burst(16, 1);
    finish_miss();

    // 3: sync with two dirty lines
    push_burst(1'b1, 32'h400, 3'd2, 0, 16);
    push_pulse(K_WBOK, 32'h0);
    push_burst(1'b1, 32'h800, 3'd6, 0, 16);
    push_pulse(K_WBOK, 32'h0);
    push_pulse(K_SDON, 32'h0);
    sync_req = 1'b1; replace_dirty = 1'b1; replace_sel = 3'd2; victim_tag = 26'h10;
    tick();
    chk("sync_force", 64'(force_sync), 64'd1);
    exp_force = 1'b1;
    tick();
    replace_sel = 3'd6; victim_tag = 26'h20;
    burst(16, 1);
    tick();
    replace_dirty = 1'b0; replace_sel = 3'd0; victim_tag = 26'h3FF;
    burst(16, 0);
    chk("sync_done_pulse", 64'(sync_done), 64'd1);
    sync_req = 1'b0;
    tick();
    exp_force = 1'b0;
    chk("sync_force_off", 64'(force_sync), 64'd0);
    chk("sync_idle_stall", 64'(core_stall), 64'd0);

    // 4: flush wins over a simultaneous miss
    push_pulse(K_VCLR, 32'h0);
    push_burst(1'b0, 32'h2000_0100, 3'd1, 0, 16);
    push_pulse(K_LREF, 32'h2000_0100);
    flush_req = 1'b1; core_req = 1'b1; line_miss = 1'b1;
    core_addr = 32'h2000_0100; replace_sel = 3'd1; replace_dirty = 1'b0;
    tick();
    chk("flush_valid_clear", 64'(valid_clear), 64'd1);
    chk("flush_no_bus",      64'(bus_req),     64'd0);
    flush_req = 1'b0;
    tick();
    tick();
    chk("flush_then_miss", 64'(bus_req), 64'd1);
    burst(16, 0);
    finish_miss();

    // 5: reset in the middle of a refill
    push_burst(1'b0, 32'h3000, 3'd4, 0, 7);
    start_miss(32'h3000, 3'd4, 26'h0, 1'b0);
    burst(7, 0);
    chk("mid_beat7", 64'(mem_beat), 64'd7);
    rst = 1'b1;
    tick();
    chk("rst_mid_bus_req", 64'(bus_req),     64'd0);
    chk("rst_mid_beat",    64'(mem_beat),    64'd0);
    chk("rst_mid_refill",  64'(line_refill), 64'd0);
    rst = 1'b0; replace_sel = 3'd7;
    push_burst(1'b0, 32'h3000, 3'd7, 0, 16);
    push_pulse(K_LREF, 32'h3000);
    tick();
    chk("restart_beat0", 64'(mem_beat), 64'd0);
    burst(16, 0);
    finish_miss();

    // 6: bus stalls for 20 cycles mid-burst
    push_burst(1'b0, 32'h4440, 3'd2, 0, 16);
    push_pulse(K_LREF, 32'h4440);
    start_miss(32'h4440, 3'd2, 26'h0, 1'b0);
    burst(5, 0);
    for (int i = 0; i < 20; i++) begin
      chk("hold_addr",  64'(bus_addr),   64'h4454);
      chk("hold_beat",  64'(mem_beat),   64'd5);
      chk("hold_stall", 64'(core_stall), 64'd1);
      tick();
    end
    burst(11, 0);
    finish_miss();

    repeat (3) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
